rx_prbs_accumulator: RTL
========================

RX_PRBS_ACCUMULATOR -- requirements
Module: rx_prbs_accumulator

Interface
REQ-001 The block SHALL have parameter SEQ_LEN, default 255, giving the chips per PRBS sequence; legal range is 2..255.
REQ-002 The block SHALL have parameter LFSR_SEED, default 8'hFF, giving the LFSR load value; it must be non-zero.
REQ-003 crx_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rrx_rst  input  1  reset, asynchronous, active-high.
REQ-005 erx_en  input  1  enable; low forces idle.
REQ-006 ibit_ready  input  1  chip-ready level from the upstream correlation unit.
REQ-007 iresult_0  input  17 signed  per-chip correlation, branch 0.
REQ-008 iresult_1  input  17 signed  per-chip correlation, branch 1 (sample+10).
REQ-009 ocorr_valid  output  1  one-cycle pulse; the sequence result is valid.
REQ-010 ocorr_0  output  25 signed  despread sum, branch 0.
REQ-011 ocorr_1  output  25 signed  despread sum, branch 1.
REQ-012 ochip_count  output  8  chips accepted in the current sequence.
REQ-013 obusy  output  1  high while in state ACCUM.

Function
REQ-014 A chip SHALL be accepted only on a 0->1 transition of ibit_ready, detected against a registered copy of ibit_ready, while erx_en=1.
REQ-015 A level held high for several cycles SHALL count as exactly one chip.
REQ-016 The state machine SHALL have two states, IDLE and ACCUM.
- IDLE->ACCUM on the first accepted chip.
- ACCUM->IDLE after the SEQ_LEN-th accepted chip, or when erx_en=0.
REQ-017 The LFSR SHALL be 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
- Update: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Advances once per accepted chip.
- The current chip is lfsr[0] before the advance.
REQ-018 When chip=1, each accumulator SHALL add its sign-extended input; when chip=0, it SHALL subtract it.
- Accumulators are 25-bit signed.
- No saturation: 255*2^16 < 2^24, so overflow cannot occur.
REQ-019 On the SEQ_LEN-th accepted chip, in the following cycle:
- ocorr_0/ocorr_1 load the final sums (including that chip);
- ocorr_valid=1 for exactly one cycle;
- accumulators, ochip_count and lfsr return to 0/0/LFSR_SEED.
REQ-020 Latency SHALL be 2 cycles from the ibit_ready rising edge to ocorr_valid: 1 cycle for edge detect, 1 cycle for accumulate/publish.
REQ-021 ocorr_0/ocorr_1 SHALL hold the last published result until the next ocorr_valid.
REQ-022 A chip edge arriving in the same cycle as the ocorr_valid pulse SHALL be accepted as chip 1 of the next sequence, with no loss.
REQ-023 When erx_en=0, on the next clock:
- state goes to IDLE;
- accumulators, ochip_count and the edge register clear;
- lfsr reloads LFSR_SEED;
- ocorr_valid=0;
- ocorr_0/ocorr_1 hold their values.
REQ-024 When erx_en falls in the same cycle as a chip edge, disable SHALL take priority and the chip SHALL be discarded.
REQ-025 ochip_count SHALL wrap to 0 only at SEQ_LEN completion and SHALL never reach SEQ_LEN.

Reset
REQ-026 When rrx_rst=1, the following SHALL take effect immediately, independent of the clock:
- state=IDLE;
- lfsr=LFSR_SEED;
- accumulators=0, edge register=0;
- ocorr_valid=0, ocorr_0=0, ocorr_1=0, ochip_count=0, obusy=0.
REQ-027 Reset asserted mid-sequence SHALL discard the partial sums; no ocorr_valid pulse SHALL follow.
REQ-028 After reset release, the first accepted chip SHALL use lfsr[0] of LFSR_SEED.

Verification
REQ-029 SEQ_LEN=4, seed FF, erx_en=1, four single-cycle ibit_ready pulses, iresult_0=100, iresult_1=-5 -> chips 1,0,0,0; ocorr_0=-200, ocorr_1=10; ocorr_valid high 1 cycle, 2 cycles after the 4th edge.
REQ-030 SEQ_LEN=4, ibit_ready held high for 3 cycles per chip -> identical results to REQ-029; ochip_count steps 1,2,3,0.
REQ-031 SEQ_LEN=4, erx_en dropped after 2 chips, then re-enabled with 4 chips of 100 -> no valid pulse after the first 2 chips; the valid pulse after the 4 new chips shows ocorr_0=-200 (LFSR restarted).
REQ-032 SEQ_LEN=4, rrx_rst pulsed asynchronously between chips 3 and 4 -> all outputs 0 immediately; no valid pulse; the next 4 chips produce a fresh result.
REQ-033 SEQ_LEN=255, iresult_0=-65536 on every chip -> ocorr_0 equals the exact sum with no overflow; iresult_0=32767 on all chips -> result matches a reference LFSR model.
REQ-034 SEQ_LEN=2, back-to-back edges with a new edge in the valid cycle -> two consecutive results, none dropped.

Source files
------------

// File: rtl/rx_prbs_accumulator.sv
// PRBS despreader for the receive path. It detects chip edges on ibit_ready and
// accumulates +/- correlation results per branch, publishing one sum per SEQ_LEN chips.
module rx_prbs_accumulator #(
  parameter int         SEQ_LEN   = 255,
  parameter logic [7:0] LFSR_SEED = 8'hFF
) (
  input  logic               crx_clk,
  input  logic               rrx_rst,
  input  logic               erx_en,
  input  logic               ibit_ready,
  input  logic signed [16:0] iresult_0,
  input  logic signed [16:0] iresult_1,
  output logic               ocorr_valid,
  output logic signed [24:0] ocorr_0,
  output logic signed [24:0] ocorr_1,
  output logic [7:0]         ochip_count,
  output logic               obusy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CHIP = 8'(SEQ_LEN - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               ready_q_r;
  logic               chip_r;
  logic signed [16:0] res0_r;
  logic signed [16:0] res1_r;
  logic signed [24:0] acc0_r;
  logic signed [24:0] acc1_r;
  logic [7:0]         lfsr_r;
  logic [7:0]         count_r;

  logic               edge_s;
  logic               take_s;
  logic               last_s;
  logic signed [24:0] ext0_s;
  logic signed [24:0] ext1_s;
  logic signed [24:0] sum0_s;
  logic signed [24:0] sum1_s;
  logic [7:0]         lfsr_nxt_s;

  assign edge_s     = erx_en & ibit_ready & ~ready_q_r;
  // A pending chip is dropped if the block is disabled in the same cycle.
  assign take_s     = erx_en & chip_r;
  assign last_s     = take_s & (count_r == LAST_CHIP);
  assign ext0_s     = {{8{res0_r[16]}}, res0_r};
  assign ext1_s     = {{8{res1_r[16]}}, res1_r};
  assign lfsr_nxt_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  assign obusy      = (state_r == ACCUM);
  assign ochip_count = count_r;

  // Despread: add on chip 1, subtract on chip 0.
  always_comb begin
    sum0_s = acc0_r;
    sum1_s = acc1_r;
    if (lfsr_r[0]) begin
      sum0_s = acc0_r + ext0_s;
      sum1_s = acc1_r + ext1_s;
    end else begin
      sum0_s = acc0_r - ext0_s;
      sum1_s = acc1_r - ext1_s;
    end
  end

  // Next-state logic for the sequence tracker.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s && !last_s) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (!erx_en || last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Edge detector; the chip's correlation values are captured with the edge.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      ready_q_r <= 1'b0;
      chip_r    <= 1'b0;
      res0_r    <= 17'sd0;
      res1_r    <= 17'sd0;
    end else if (!erx_en) begin
      ready_q_r <= 1'b0;
      chip_r    <= 1'b0;
      res0_r    <= 17'sd0;
      res1_r    <= 17'sd0;
    end else begin
      ready_q_r <= ibit_ready;
      chip_r    <= edge_s;
      if (edge_s) begin
        res0_r <= iresult_0;
        res1_r <= iresult_1;
      end
    end
  end

  // Accumulators, chip counter, LFSR and published result.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      acc0_r      <= 25'sd0;
      acc1_r      <= 25'sd0;
      count_r     <= 8'd0;
      lfsr_r      <= LFSR_SEED;
      ocorr_valid <= 1'b0;
      ocorr_0     <= 25'sd0;
      ocorr_1     <= 25'sd0;
    end else begin
      ocorr_valid <= 1'b0;
      if (!erx_en) begin
        acc0_r  <= 25'sd0;
        acc1_r  <= 25'sd0;
        count_r <= 8'd0;
        lfsr_r  <= LFSR_SEED;
      end else if (last_s) begin
        ocorr_0     <= sum0_s;
        ocorr_1     <= sum1_s;
        ocorr_valid <= 1'b1;
        acc0_r      <= 25'sd0;
        acc1_r      <= 25'sd0;
        count_r     <= 8'd0;
        lfsr_r      <= LFSR_SEED;
      end else if (take_s) begin
        acc0_r  <= sum0_s;
        acc1_r  <= sum1_s;
        count_r <= count_r + 8'd1;
        lfsr_r  <= lfsr_nxt_s;
      end
    end
  end

endmodule
